// File: rtl/regfile_bus_pkg.sv
// ============================================================================
// Module   : regfile_bus_pkg
// Brief    : Shared types, default widths and helpers for the regfile bus arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int c_DEF_NUM_REQ     = 2;
    localparam int c_DEF_ADDR_WIDTH  = 32;
    localparam int c_DEF_WDATA_WIDTH = 32;
    localparam int c_DEF_RDATA_WIDTH = 32;

    // Never returns 0, so a pointer always has at least one bit.
    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_bus_arbiter_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker; search starts at ptr and wraps
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import regfile_bus_pkg::*;
#(
    parameter int NUM_REQ   = c_DEF_NUM_REQ,
    parameter int PTR_WIDTH = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   eligible,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   grant,
    output logic [PTR_WIDTH-1:0] grant_idx,
    output logic                 any_grant
);

    logic [PTR_WIDTH-1:0] w_cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        w_cand    = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_grant && eligible[w_cand]) begin
                any_grant        = 1'b1;
                grant[w_cand]    = 1'b1;
                grant_idx        = w_cand;
            end
            // Explicit wrap keeps non-power-of-two NUM_REQ in range.
            w_cand = (w_cand == PTR_WIDTH'(NUM_REQ - 1)) ? '0 : w_cand + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_bus_arbiter.sv
// ============================================================================
// Module   : regfile_bus_arbiter
// Brief    : Round-robin sharing of one regfile bus; fixed two-cycle access
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_bus_arbiter
    import regfile_bus_pkg::*;
#(
    parameter int NUM_REQ     = c_DEF_NUM_REQ,
    parameter int ADDR_WIDTH  = c_DEF_ADDR_WIDTH,
    parameter int WDATA_WIDTH = c_DEF_WDATA_WIDTH,
    parameter int RDATA_WIDTH = c_DEF_RDATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*WDATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             done,
    output logic [RDATA_WIDTH-1:0]         rd_data,
    output logic [ADDR_WIDTH-1:0]          reg_addr,
    output logic [WDATA_WIDTH-1:0]         reg_wdata,
    output logic                           reg_en,
    output logic                           reg_we,
    input  logic [RDATA_WIDTH-1:0]         reg_rdata
);

    localparam int c_PTR_WIDTH = clog2_min1(NUM_REQ);

    state_t                   r_state;
    logic [c_PTR_WIDTH-1:0]   r_ptr;
    logic [NUM_REQ-1:0]       r_win;
    logic                     r_we;

    logic [NUM_REQ-1:0]       w_eligible;
    logic [NUM_REQ-1:0]       w_win_onehot;
    logic [c_PTR_WIDTH-1:0]   w_win_idx;
    logic [c_PTR_WIDTH-1:0]   w_next_ptr;
    logic                     w_any;
    logic                     w_sel_we;
    logic [ADDR_WIDTH-1:0]    w_sel_addr;
    logic [WDATA_WIDTH-1:0]   w_sel_wdata;

    // The requester finishing this cycle is masked so a held req is not re-served.
    assign w_eligible = req & ~done;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .PTR_WIDTH (c_PTR_WIDTH)
    ) u_rr_arbiter (
        .eligible  (w_eligible),
        .ptr       (r_ptr),
        .grant     (w_win_onehot),
        .grant_idx (w_win_idx),
        .any_grant (w_any)
    );

    assign w_next_ptr = (w_win_idx == c_PTR_WIDTH'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_onehot[i]) begin
                w_sel_we    = req_we[i];
                w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = req_wdata[i*WDATA_WIDTH +: WDATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_we      <= 1'b0;
            gnt       <= '0;
            done      <= '0;
            rd_data   <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_en    <= 1'b0;
            reg_we    <= 1'b0;
        end else begin
            done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state   <= ACCESS;
                        r_ptr     <= w_next_ptr;
                        r_win     <= w_win_onehot;
                        r_we      <= w_sel_we;
                        gnt       <= w_win_onehot;
                        reg_en    <= 1'b1;
                        reg_we    <= w_sel_we;
                        reg_addr  <= w_sel_addr;
                        reg_wdata <= w_sel_wdata;
                    end
                end
                ACCESS: begin
                    // Address and write data stay put so the regfile samples them in HOLD.
                    r_state <= HOLD;
                    reg_en  <= 1'b0;
                    reg_we  <= 1'b0;
                end
                HOLD: begin
                    if (!r_we) begin
                        rd_data <= reg_rdata;
                    end
                    done    <= r_win;
                    gnt     <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    gnt     <= '0;
                    reg_en  <= 1'b0;
                    reg_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
